if_fetch_buf: RTL and testbench
===============================

Name: if_fetch_buf

Overview:
- Fetch stage sitting between the PC stage and decode.
- Takes the current PC, issues one instruction-memory read per PC, and captures the returned 32-bit instruction together with its PC.
- Holds instructions in a small FIFO and presents them to decode over a valid/ready handshake.
- Flushes on a control-flow redirect and drops any stale memory response still in flight.

Parameters:
- ADDR_W, 64, PC / instruction-memory address width.
- INST_W, 32, instruction width.
- DEPTH, 2, FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc_valid  in  1  PC stage offers pc_addr.
- pc_addr  in  ADDR_W  address to fetch.
- pc_ready  out  1  PC accepted this cycle; PC stage advances on pc_valid&pc_ready.
- flush  in  1  redirect (jump/taken branch); discard all buffered and in-flight fetches.
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_W  request address.
- imem_ack  in  1  request accepted by memory.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  INST_W  response instruction.
- id_valid  out  1  FIFO head valid to decode.
- id_ready  in  1  decode consumes head.
- id_inst  out  INST_W  head instruction.
- id_pc  out  ADDR_W  head PC.

Behaviour:
- Reset (rst=0, async): state=IDLE; FIFO empty; imem_req=0, imem_addr=0, pc_ready=0, id_valid=0, id_inst=0, id_pc=0.
- At most one outstanding memory request.
- Issue is permitted when fifo_count + outstanding < DEPTH.
- FSM states and transitions:
  - IDLE: pc_ready = issue-permitted & ~flush. On pc_valid&pc_ready, latch pc_addr into req_pc and go to REQ.
  - REQ: imem_req=1, imem_addr=req_pc. imem_ack → RESP. flush → IDLE; the request is withdrawn and has no side effects.
  - RESP: wait for imem_rvalid, then push {req_pc, imem_rdata} and go to IDLE. flush without imem_rvalid in the same cycle → DROP. flush with imem_rvalid in the same cycle → response discarded, go to IDLE.
  - DROP: imem_req=0, pc_ready=0. Discard the next imem_rvalid, then go to IDLE. A flush while in DROP stays in DROP.
- Latency: PC accepted in cycle N, imem_req in N+1. With imem_ack in N+1 and imem_rvalid in N+2, the entry is visible on id_valid in N+3 (push registered).
- Throughput: one instruction per 3 cycles with single-cycle memory; full overlap is not required.
- FIFO:
  - Registered storage with wrap-around pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.
  - id_* driven from the head entry; id_inst and id_pc hold their last value when id_valid=0.
  - Pop on id_valid&id_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Flush:
  - Clears the FIFO; id_valid=0 from the next cycle.
  - A pop in the flush cycle is still honoured.
  - pc_ready=0 during the flush cycle.
- Full:
  - pc_ready=0 whenever no slot is reserved-free.
  - A push never occurs while the FIFO is full, guaranteed by the reservation rule.
- imem_rvalid outside RESP/DROP is ignored.
- Asserting rst at any point, including mid-request, returns to the reset state immediately. The memory side must tolerate the abandoned request.

Test Plan:
1. Reset then pc_valid=1, pc_addr=0x8000_0000, memory acks the request next cycle and responds with rdata=0x0000_0013 one cycle later, id_ready=1 → id_valid=1 with id_pc=0x8000_0000, id_inst=0x00000013, 3 cycles after PC acceptance.
2. id_ready=0, fetch 0x8000_0000 then 0x8000_0004 → FIFO holds 2 entries, pc_ready stays 0. Raise id_ready → entries pop in order, then pc_ready reasserts.
3. Flush asserted while in RESP for PC 0x8000_0008. Response arrives 2 cycles later with 0xDEADBEEF → response dropped, id_valid stays 0, next fetch of 0x8000_1000 delivers its own data only.
4. Flush and imem_rvalid in the same cycle in RESP → no push; state=IDLE next cycle; FIFO empty.
5. Pop and push in the same cycle with 1 entry held → count stays 1, head advances correctly. Run 8 back-to-back fetches to exercise pointer wrap with DEPTH=2.
6. rst driven low mid-REQ (imem_req=1) → imem_req, pc_ready and id_valid go to 0 asynchronously, without waiting for a clock edge. Release and refetch 0x8000_0000 → normal delivery.

Source files
------------

// File: rtl/if_fetch_buf_if.sv
// Fetch-buffer bus bundle: PC-stage handshake, instruction-memory channel,
// redirect flush and the decode-side valid/ready channel.
// The fetch buffer connects through the slave modport; the environment
// (PC stage, memory, decode) uses the master modport.
interface if_fetch_buf_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              pc_valid;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_ready;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;

  modport master (
    output pc_valid, pc_addr, flush, imem_ack, imem_rvalid, imem_rdata, id_ready,
    input  pc_ready, imem_req, imem_addr, id_valid, id_inst, id_pc
  );

  modport slave (
    input  pc_valid, pc_addr, flush, imem_ack, imem_rvalid, imem_rdata, id_ready,
    output pc_ready, imem_req, imem_addr, id_valid, id_inst, id_pc
  );
endinterface

// File: rtl/if_fetch_buf.sv
// Instruction fetch buffer: accepts one PC at a time, issues a single
// instruction-memory read, captures {pc, inst} into a small FIFO and hands
// entries to decode over valid/ready. A redirect flush empties the FIFO and
// discards any memory response that is still in flight.
module if_fetch_buf #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  if_fetch_buf_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              run_r;
  logic [ADDR_W-1:0] req_pc_r;
  logic [INST_W-1:0] mem_inst_r [DEPTH];
  logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [INST_W-1:0] head_inst_r;
  logic [ADDR_W-1:0] head_pc_r;
  logic              fifo_nempty_s;
  logic              issue_ok_s;
  logic              pc_ready_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;

  // Handshake qualifiers. New PCs are only taken in IDLE, where nothing is
  // outstanding, so the slot reservation reduces to "FIFO not full".
  always_comb begin
    fifo_nempty_s = (count_r != CNT_ZERO);
    issue_ok_s    = (count_r < CNT_FULL);
    pc_ready_s    = run_r & (state_r == ST_IDLE) & issue_ok_s & ~bus.flush;
    accept_s      = bus.pc_valid & pc_ready_s;
    push_s        = (state_r == ST_RESP) & bus.imem_rvalid & ~bus.flush;
    pop_s         = fifo_nempty_s & bus.id_ready;
  end

  // Request FSM next state: one outstanding read, flush-aware.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_REQ;
        else          state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (bus.flush)         state_nxt_s = ST_IDLE;
        else if (bus.imem_ack) state_nxt_s = ST_RESP;
        else                   state_nxt_s = ST_REQ;
      end
      ST_RESP: begin
        if (bus.imem_rvalid) state_nxt_s = ST_IDLE;
        else if (bus.flush)  state_nxt_s = ST_DROP;
        else                 state_nxt_s = ST_RESP;
      end
      ST_DROP: begin
        if (bus.imem_rvalid) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_DROP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; flush empties the queue outright.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    if (bus.flush) begin
      rd_ptr_nxt_s = PTR_ZERO;
      wr_ptr_nxt_s = PTR_ZERO;
      count_nxt_s  = CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      else        wr_ptr_nxt_s = wr_ptr_r;
      if (pop_s)  rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      else        rd_ptr_nxt_s = rd_ptr_r;
      if (push_s && !pop_s)      count_nxt_s = count_r + CNT_ONE;
      else if (!push_s && pop_s) count_nxt_s = count_r - CNT_ONE;
      else                       count_nxt_s = count_r;
    end
  end

  // FSM state, request address, and a run flag that keeps pc_ready low
  // until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      run_r    <= 1'b0;
      req_pc_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      run_r   <= 1'b1;
      if (accept_s) req_pc_r <= bus.pc_addr;
      else          req_pc_r <= req_pc_r;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_r[i] <= {INST_W{1'b0}};
        mem_pc_r[i]   <= {ADDR_W{1'b0}};
      end
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_inst_r[wr_ptr_r] <= bus.imem_rdata;
        mem_pc_r[wr_ptr_r]   <= req_pc_r;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Registered head copy feeding decode. It tracks the next-cycle head
  // (bypassing a push that lands directly at the head) and holds its last
  // value whenever the FIFO goes empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_inst_r <= {INST_W{1'b0}};
      head_pc_r   <= {ADDR_W{1'b0}};
    end else if (count_nxt_s != CNT_ZERO) begin
      if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
        head_inst_r <= bus.imem_rdata;
        head_pc_r   <= req_pc_r;
      end else begin
        head_inst_r <= mem_inst_r[rd_ptr_nxt_s];
        head_pc_r   <= mem_pc_r[rd_ptr_nxt_s];
      end
    end else begin
      head_inst_r <= head_inst_r;
      head_pc_r   <= head_pc_r;
    end
  end

  assign bus.pc_ready  = pc_ready_s;
  assign bus.imem_req  = (state_r == ST_REQ);
  assign bus.imem_addr = req_pc_r;
  assign bus.id_valid  = fifo_nempty_s;
  assign bus.id_inst   = head_inst_r;
  assign bus.id_pc     = head_pc_r;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf: a per-cycle vector table for the main
// fetch/flush/full scenarios, plus hand-written sequences for pointer wrap
// and asynchronous reset during a request.
module tb_if_fetch_buf;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  if_fetch_buf_if #(.ADDR_W(64), .INST_W(32)) bus ();

  if_fetch_buf #(.ADDR_W(64), .INST_W(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [63:0] pa;
    logic        fl;
    logic        ack;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_pr;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl [33];

  function automatic vec_t mk(logic pv, logic [63:0] pa, logic fl, logic ack,
                              logic rv, logic [31:0] rd, logic ir,
                              logic e_pr, logic e_req, logic [63:0] e_addr,
                              logic e_iv, logic [31:0] e_inst, logic [63:0] e_pc);
    vec_t v;
    v.pv = pv; v.pa = pa; v.fl = fl; v.ack = ack; v.rv = rv; v.rd = rd; v.ir = ir;
    v.e_pr = e_pr; v.e_req = e_req; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, settle, then return.
  task automatic drive(input logic pv, input logic [63:0] pa, input logic fl,
                       input logic ack, input logic rv, input logic [31:0] rd,
                       input logic ir);
    @(negedge clk);
    bus.pc_valid    = pv;
    bus.pc_addr     = pa;
    bus.flush       = fl;
    bus.imem_ack    = ack;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.id_ready    = ir;
    #1;
  endtask

  localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A4 = 64'h0000_0000_8000_0004;
  localparam logic [63:0] A8 = 64'h0000_0000_8000_0008;
  localparam logic [63:0] B0 = 64'h0000_0000_8000_1000;
  localparam logic [63:0] C0 = 64'h0000_0000_8000_2000;
  localparam logic [63:0] D0 = 64'h0000_0000_8000_3000;
  localparam logic [63:0] D4 = 64'h0000_0000_8000_3004;
  localparam logic [63:0] Z  = 64'h0;
  localparam logic [31:0] I13 = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h1111_1111;
  localparam logic [31:0] I2  = 32'h2222_2222;
  localparam logic [31:0] IB  = 32'h0010_0093;
  localparam logic [31:0] IA1 = 32'hA1A1_A1A1;
  localparam logic [31:0] IA2 = 32'hA2A2_A2A2;

  initial begin
    logic [31:0] prev_inst;
    logic [63:0] prev_pc;
    logic [63:0] addr_k;
    logic [31:0] data_k;
    checks = 0;
    errors = 0;

    // pv  pa  fl ack rv rd            ir | pr req addr iv inst pc
    // Test 1: single fetch, 3-cycle latency
    tbl[0]  = mk(1'b1, A0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, Z,  1'b0, 32'h0, Z);
    tbl[1]  = mk(1'b0, Z,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, A0, 1'b0, 32'h0, Z);
    tbl[2]  = mk(1'b0, Z,  1'b0, 1'b0, 1'b1, I13,           1'b1, 1'b0, 1'b0, Z,  1'b0, 32'h0, Z);
    tbl[3]  = mk(1'b0, Z,  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, Z,  1'b1, I13,   A0);
    tbl[4]  = mk(1'b0, Z,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, Z,  1'b0, I13,   A0);
    // Test 2: fill both slots with decode stalled, then drain in order
    tbl[5]  = mk(1'b1, A0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, Z,  1'b0, I13,   A0);
    tbl[6]  = mk(1'b0, Z,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, A0, 1'b0, I13,   A0);
    tbl[7]  = mk(1'b0, Z,  1'b0, 1'b0, 1'b1, I1,            1'b0, 1'b0, 1'b0, Z,  1'b0, I13,   A0);
    tbl[8]  = mk(1'b1, A4, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, Z,  1'b1, I1,    A0);
    tbl[9]  = mk(1'b0, Z,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, A4, 1'b1, I1,    A0);
    tbl[10] = mk(1'b0, Z,  1'b0, 1'b0, 1'b1, I2,            1'b0, 1'b0, 1'b0, Z,  1'b1, I1,    A0);
    tbl[11] = mk(1'b1, A8, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, Z,  1'b1, I1,    A0);
    tbl[12] = mk(1'b1, A8, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, Z,  1'b1, I1,    A0);
    tbl[13] = mk(1'b1, A8, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, Z,  1'b1, I2,    A4);
    // Test 3: flush in RESP, stale response two cycles later is dropped
    tbl[14] = mk(1'b0, Z,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, A8, 1'b0, I2,    A4);
    tbl[15] = mk(1'b0, Z,  1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, Z,  1'b0, I2,    A4);
    tbl[16] = mk(1'b0, Z,  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, Z,  1'b0, I2,    A4);
    tbl[17] = mk(1'b0, Z,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 1'b0, Z,  1'b0, I2,    A4);
    tbl[18] = mk(1'b1, B0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, Z,  1'b0, I2,    A4);
    tbl[19] = mk(1'b0, Z,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, B0, 1'b0, I2,    A4);
    tbl[20] = mk(1'b0, Z,  1'b0, 1'b0, 1'b1, IB,            1'b1, 1'b0, 1'b0, Z,  1'b0, I2,    A4);
    tbl[21] = mk(1'b0, Z,  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, Z,  1'b1, IB,    B0);
    // Test 4: flush coincident with the response
    tbl[22] = mk(1'b1, C0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, Z,  1'b0, IB,    B0);
    tbl[23] = mk(1'b0, Z,  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, C0, 1'b0, IB,    B0);
    tbl[24] = mk(1'b0, Z,  1'b1, 1'b0, 1'b1, 32'hCAFEBABE,  1'b1, 1'b0, 1'b0, Z,  1'b0, IB,    B0);
    tbl[25] = mk(1'b0, Z,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, Z,  1'b0, IB,    B0);
    // Test 5a: push and pop in the same cycle with one entry held
    tbl[26] = mk(1'b1, D0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, Z,  1'b0, IB,    B0);
    tbl[27] = mk(1'b0, Z,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, D0, 1'b0, IB,    B0);
    tbl[28] = mk(1'b0, Z,  1'b0, 1'b0, 1'b1, IA1,           1'b0, 1'b0, 1'b0, Z,  1'b0, IB,    B0);
    tbl[29] = mk(1'b1, D4, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, Z,  1'b1, IA1,   D0);
    tbl[30] = mk(1'b0, Z,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, D4, 1'b1, IA1,   D0);
    tbl[31] = mk(1'b0, Z,  1'b0, 1'b0, 1'b1, IA2,           1'b1, 1'b0, 1'b0, Z,  1'b1, IA1,   D0);
    tbl[32] = mk(1'b0, Z,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, Z,  1'b1, IA2,   D4);

    // Reset state
    rst = 1'b0;
    bus.pc_valid = 1'b0; bus.pc_addr = 64'h0; bus.flush = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.id_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc_ready",  {63'h0, bus.pc_ready}, 64'h0);
    check("rst_imem_req",  {63'h0, bus.imem_req}, 64'h0);
    check("rst_imem_addr", bus.imem_addr,         64'h0);
    check("rst_id_valid",  {63'h0, bus.id_valid}, 64'h0);
    check("rst_id_inst",   {32'h0, bus.id_inst},  64'h0);
    check("rst_id_pc",     bus.id_pc,             64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    // Table-driven section
    for (int i = 0; i < 33; i++) begin
      drive(tbl[i].pv, tbl[i].pa, tbl[i].fl, tbl[i].ack, tbl[i].rv, tbl[i].rd, tbl[i].ir);
      check($sformatf("v%0d_pc_ready", i), {63'h0, bus.pc_ready}, {63'h0, tbl[i].e_pr});
      check($sformatf("v%0d_imem_req", i), {63'h0, bus.imem_req}, {63'h0, tbl[i].e_req});
      if (tbl[i].e_req) check($sformatf("v%0d_imem_addr", i), bus.imem_addr, tbl[i].e_addr);
      check($sformatf("v%0d_id_valid", i), {63'h0, bus.id_valid}, {63'h0, tbl[i].e_iv});
      check($sformatf("v%0d_id_inst", i),  {32'h0, bus.id_inst},  {32'h0, tbl[i].e_inst});
      check($sformatf("v%0d_id_pc", i),    bus.id_pc,             tbl[i].e_pc);
    end

    // Test 5b: 8 back-to-back fetches with decode always ready (pointer wrap)
    prev_inst = IA2;
    prev_pc   = D4;
    for (int k = 0; k < 8; k++) begin
      addr_k = 64'h0000_0000_8000_4000 + 64'(k) * 64'd4;
      data_k = 32'h0000_1000 + 32'(k);
      drive(1'b1, addr_k, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check($sformatf("wrap%0d_pc_ready", k), {63'h0, bus.pc_ready}, 64'h1);
      check($sformatf("wrap%0d_id_valid", k), {63'h0, bus.id_valid}, 64'h1);
      check($sformatf("wrap%0d_id_inst", k),  {32'h0, bus.id_inst},  {32'h0, prev_inst});
      check($sformatf("wrap%0d_id_pc", k),    bus.id_pc,             prev_pc);
      drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      check($sformatf("wrap%0d_imem_req", k),  {63'h0, bus.imem_req}, 64'h1);
      check($sformatf("wrap%0d_imem_addr", k), bus.imem_addr,         addr_k);
      check($sformatf("wrap%0d_empty", k),     {63'h0, bus.id_valid}, 64'h0);
      drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, data_k, 1'b1);
      prev_inst = data_k;
      prev_pc   = addr_k;
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_last_valid", {63'h0, bus.id_valid}, 64'h1);
    check("wrap_last_inst",  {32'h0, bus.id_inst},  {32'h0, prev_inst});
    check("wrap_last_pc",    bus.id_pc,             prev_pc);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_drained", {63'h0, bus.id_valid}, 64'h0);

    // Test 6: async reset while a request is outstanding
    drive(1'b1, 64'h0000_0000_8000_5000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 32'hB1B1_B1B1, 1'b0);
    drive(1'b1, 64'h0000_0000_8000_5004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("pre_rst_imem_req", {63'h0, bus.imem_req}, 64'h1);
    check("pre_rst_id_valid", {63'h0, bus.id_valid}, 64'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_imem_req", {63'h0, bus.imem_req}, 64'h0);
    check("async_rst_pc_ready", {63'h0, bus.pc_ready}, 64'h0);
    check("async_rst_id_valid", {63'h0, bus.id_valid}, 64'h0);
    check("async_rst_id_inst",  {32'h0, bus.id_inst},  64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    drive(1'b1, A0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("refetch_pc_ready", {63'h0, bus.pc_ready}, 64'h1);
    drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("refetch_imem_req",  {63'h0, bus.imem_req}, 64'h1);
    check("refetch_imem_addr", bus.imem_addr,         A0);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, I13, 1'b1);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("refetch_id_valid", {63'h0, bus.id_valid}, 64'h1);
    check("refetch_id_inst",  {32'h0, bus.id_inst},  {32'h0, I13});
    check("refetch_id_pc",    bus.id_pc,             A0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
